// File: rtl/pipe_stage_chain.sv
// Chain of valid-tagged pipeline registers with per-stage stall/flush, optional
// bubble collapse and saturating stall/flush performance counters.
module pipe_stage_chain #(
    parameter int unsigned       DATA_W          = 32,
    parameter int unsigned       DEPTH           = 4,
    parameter logic [DATA_W-1:0] PRESET_VAL      = '0,
    parameter bit                BUBBLE_COLLAPSE = 1'b1,
    parameter int unsigned       CNT_W           = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic [DEPTH-1:0]  stall,
    input  logic [DEPTH-1:0]  flush,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [DEPTH-1:0]  hold,
    output logic              in_ready,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_kills
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  v_q, v_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;

    // What each stage would load when it advances: din for stage 0, else its predecessor.
    logic [DATA_W-1:0] up_data [DEPTH];
    logic [DEPTH-1:0]  up_valid;
    logic [DEPTH-1:0]  up_hold;

    always_comb begin
        logic [DEPTH-1:0] h;
        h[DEPTH-1] = stall[DEPTH-1];
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            if (BUBBLE_COLLAPSE) h[i] = stall[i] | (h[i+1] & v_q[i+1]);
            else                 h[i] = stall[i] | h[i+1];
        end
        hold = h;
    end

    always_comb begin
        up_data[0]  = din;
        up_valid[0] = din_valid;
        up_hold[0]  = 1'b0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            up_data[i]  = data_q[i-1];
            up_valid[i] = v_q[i-1];
            up_hold[i]  = hold[i-1];
        end
    end

    always_comb begin
        logic [3:0]       kill_n;
        logic [CNT_W+4:0] kill_sum;
        v_d         = v_q;
        data_d      = data_q;
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        kill_n      = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            kill_n = kill_n + {3'b000, flush[i] & v_q[i]};
        end
        kill_sum = {5'b00000, kill_cnt_q} + (CNT_W+5)'(kill_n);
        if (enable) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (flush[i]) begin
                    v_d[i]    = 1'b0;
                    data_d[i] = PRESET_VAL;
                end else if (hold[i]) begin
                    v_d[i]    = v_q[i];
                    data_d[i] = data_q[i];
                end else if (!up_hold[i]) begin
                    v_d[i]    = up_valid[i];
                    data_d[i] = up_data[i];
                end else begin
                    v_d[i]    = 1'b0;
                    data_d[i] = PRESET_VAL;
                end
            end
            if (clr_cnt) begin
                stall_cnt_d = '0;
                kill_cnt_d  = '0;
            end else begin
                if (|(hold & v_q) && stall_cnt_q != CntMax) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
                if (kill_sum > {5'b00000, CntMax}) kill_cnt_d = CntMax;
                else                               kill_cnt_d = kill_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            v_q         <= '0;
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= PRESET_VAL;
        end else begin
            v_q         <= v_d;
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
            for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= data_d[i];
        end
    end

    assign dout         = data_q[DEPTH-1];
    assign dout_valid   = v_q[DEPTH-1];
    assign stage_valid  = v_q;
    assign in_ready     = enable & ~hold[0];
    assign stall_cycles = stall_cnt_q;
    assign flush_kills  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives three pipe_stage_chain variants (collapse on, collapse off, 2-bit counters)
// with shared stimulus and compares each against an array-based reference model.
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic [3:0]  stall = '0;
    logic [3:0]  flush = '0;
    logic        clr_cnt = 1'b0;

    logic [31:0] dout_w [3];
    logic        dv_w   [3];
    logic [3:0]  sv_w   [3];
    logic [3:0]  hold_w [3];
    logic        ir_w   [3];
    logic [15:0] sc_w   [3];
    logic [15:0] fk_w   [3];
    logic [1:0]  sc2, fk2;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: per instance, per stage valid/data plus counters.
    bit          mv  [3][4];
    logic [31:0] md  [3][4];
    int          msc [3];
    int          mfk [3];
    int          cmax [3] = '{65535, 65535, 3};
    bit          bc   [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    pipe_stage_chain u_bc1 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .din(din), .din_valid(din_valid),
        .stall(stall), .flush(flush), .clr_cnt(clr_cnt), .dout(dout_w[0]),
        .dout_valid(dv_w[0]), .stage_valid(sv_w[0]), .hold(hold_w[0]), .in_ready(ir_w[0]),
        .stall_cycles(sc_w[0]), .flush_kills(fk_w[0])
    );

    pipe_stage_chain #(.BUBBLE_COLLAPSE(1'b0)) u_bc0 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .din(din), .din_valid(din_valid),
        .stall(stall), .flush(flush), .clr_cnt(clr_cnt), .dout(dout_w[1]),
        .dout_valid(dv_w[1]), .stage_valid(sv_w[1]), .hold(hold_w[1]), .in_ready(ir_w[1]),
        .stall_cycles(sc_w[1]), .flush_kills(fk_w[1])
    );

    pipe_stage_chain #(.CNT_W(2)) u_c2 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .din(din), .din_valid(din_valid),
        .stall(stall), .flush(flush), .clr_cnt(clr_cnt), .dout(dout_w[2]),
        .dout_valid(dv_w[2]), .stage_valid(sv_w[2]), .hold(hold_w[2]), .in_ready(ir_w[2]),
        .stall_cycles(sc2), .flush_kills(fk2)
    );

    assign sc_w[2] = {14'd0, sc2};
    assign fk_w[2] = {14'd0, fk2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A stage is held if stalled, or if the stage after it is held and (when
    // collapsing) actually occupied.
    function automatic logic [3:0] mhold(int k);
        logic [3:0] h;
        h[3] = stall[3];
        for (int i = 2; i >= 0; i--) h[i] = stall[i] | (h[i+1] & (bc[k] ? mv[k][i+1] : 1'b1));
        return h;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                mv[k][i] = 1'b0;
                md[k][i] = '0;
            end
            msc[k] = 0;
            mfk[k] = 0;
        end
    endtask

    task automatic model_step();
        bit          nv [4];
        logic [31:0] nd [4];
        logic [3:0]  h;
        int          kills;
        bit          any_held;
        if (!enable) return;
        for (int k = 0; k < 3; k++) begin
            h = mhold(k);
            kills = 0;
            any_held = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (flush[i] && mv[k][i]) kills++;
                if (h[i] && mv[k][i]) any_held = 1'b1;
                if (flush[i])      begin nv[i] = 1'b0;        nd[i] = '0;          end
                else if (h[i])     begin nv[i] = mv[k][i];    nd[i] = md[k][i];    end
                else if (i == 0)   begin nv[i] = din_valid;   nd[i] = din;         end
                else if (!h[i-1])  begin nv[i] = mv[k][i-1];  nd[i] = md[k][i-1];  end
                else               begin nv[i] = 1'b0;        nd[i] = '0;          end
            end
            for (int i = 0; i < 4; i++) begin
                mv[k][i] = nv[i];
                md[k][i] = nd[i];
            end
            if (clr_cnt) begin
                msc[k] = 0;
                mfk[k] = 0;
            end else begin
                if (any_held && msc[k] < cmax[k]) msc[k]++;
                mfk[k] = (mfk[k] + kills > cmax[k]) ? cmax[k] : mfk[k] + kills;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] ev;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) ev[i] = mv[k][i];
            chk($sformatf("i%0d.stage_valid", k), 64'(sv_w[k]), 64'(ev));
            chk($sformatf("i%0d.dout_valid", k), 64'(dv_w[k]), 64'(mv[k][3]));
            chk($sformatf("i%0d.dout", k), 64'(dout_w[k]), 64'(md[k][3]));
            chk($sformatf("i%0d.hold", k), 64'(hold_w[k]), 64'(mhold(k)));
            chk($sformatf("i%0d.in_ready", k), 64'(ir_w[k]), 64'(enable & ~mhold(k)));
            chk($sformatf("i%0d.stall_cycles", k), 64'(sc_w[k]), 64'(msc[k]));
            chk($sformatf("i%0d.flush_kills", k), 64'(fk_w[k]), 64'(mfk[k]));
        end
    endtask

    // Inputs are set just after an edge; compare, advance model, take the edge.
    task automatic tick();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit dv, input logic [31:0] d, input logic [3:0] st,
                       input logic [3:0] fl);
        din_valid = dv;
        din       = d;
        stall     = st;
        flush     = fl;
        tick();
    endtask

    initial begin
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b1;

        // Reset mid-stream: must clear before any clock edge.
        drv(1, 32'h11, 4'h0, 4'h0);
        drv(1, 32'h22, 4'h0, 4'h0);
        drv(1, 32'h33, 4'h0, 4'h0);
        arst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_reset.stage_valid", 64'(sv_w[0]), 64'h0);
        #1;
        arst_n = 1'b1;

        // Streaming A0..A7 then drain.
        for (int j = 0; j < 8; j++) drv(1, 32'hA0 + 32'(j), 4'h0, 4'h0);
        for (int j = 0; j < 4; j++) drv(0, 32'h0, 4'h0, 4'h0);

        // Fill, then stall stage 2 for two cycles.
        for (int j = 0; j < 4; j++) drv(1, 32'hB0 + 32'(j), 4'h0, 4'h0);
        drv(1, 32'hB4, 4'b0100, 4'h0);
        drv(1, 32'hB4, 4'b0100, 4'h0);
        drv(1, 32'hB4, 4'h0, 4'h0);

        // Bubble collapse: only stage 0 valid, stall the empty last stage.
        drv(0, 32'h0, 4'h0, 4'hF);
        drv(1, 32'hC0, 4'h0, 4'h0);
        drv(1, 32'hC1, 4'b1000, 4'h0);
        drv(0, 32'h0, 4'b1000, 4'h0);
        drv(0, 32'h0, 4'h0, 4'h0);

        // Flush over stall.
        for (int j = 0; j < 4; j++) drv(1, 32'hD0 + 32'(j), 4'h0, 4'h0);
        drv(1, 32'hD4, 4'b0010, 4'b0110);
        drv(0, 32'h0, 4'h0, 4'h0);

        // Counter saturation, clear, then freeze under enable=0.
        for (int j = 0; j < 4; j++) drv(1, 32'hE0 + 32'(j), 4'h0, 4'h0);
        for (int j = 0; j < 5; j++) drv(1, 32'hE4, 4'b1000, 4'h0);
        chk("c2.stall_sat", 64'(sc2), 64'd3);
        clr_cnt = 1'b1;
        drv(1, 32'hE4, 4'h0, 4'h0);
        clr_cnt = 1'b0;
        chk("c2.stall_clr", 64'(sc2), 64'd0);
        chk("c2.kills_clr", 64'(fk2), 64'd0);
        enable = 1'b0;
        for (int j = 0; j < 3; j++) drv(1, $urandom, 4'(j), 4'h0);
        enable = 1'b1;

        // Randomized traffic.
        for (int j = 0; j < 400; j++) begin
            enable    = ($urandom % 16) != 0;
            clr_cnt   = ($urandom % 32) == 0;
            for (int i = 0; i < 4; i++) begin
                stall[i] = ($urandom % 8) == 0;
                flush[i] = ($urandom % 16) == 0;
            end
            din       = $urandom;
            din_valid = $urandom % 2;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of pipeline registers with valid bits, per-stage stall and flush, optional bubble collapse, and saturating stall/flush performance counters.
- Replaces the hand-wired IF/ID, ID/EX, EX/MEM and MEM/WB registers inside cpu with one block, giving the pipeline hazard and flush control.
- Stage 0 is fed by din. Stage DEPTH-1 drives dout.

Parameters:
- DATA_W, 32: payload width per stage.
- DEPTH, 4: number of stages, legal range 1..8.
- PRESET_VAL, 0: payload value loaded on reset, flush or bubble.
- BUBBLE_COLLAPSE, 1: when 1, an empty stage never blocks upstream. When 0, a hold propagates upstream unconditionally.
- CNT_W, 16: width of each performance counter.

Ports:
- clk, input, 1: main clock.
- arst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: global advance. When 0, all state including counters is frozen.
- din, input, DATA_W: payload into stage 0.
- din_valid, input, 1: din carries a live entry.
- stall, input, DEPTH: stall[i] holds stage i.
- flush, input, DEPTH: flush[i] clears stage i at the next edge.
- clr_cnt, input, 1: synchronous clear of both counters.
- dout, output, DATA_W: payload of stage DEPTH-1.
- dout_valid, output, 1: valid bit of stage DEPTH-1.
- stage_valid, output, DEPTH: valid bit of every stage.
- hold, output, DEPTH: combinational per-stage hold vector.
- in_ready, output, 1: equals enable & ~hold[0].
- stall_cycles, output, CNT_W: saturating count of cycles in which any valid stage was held.
- flush_kills, output, CNT_W: saturating count of valid entries destroyed by flush.

Behaviour:
- Reset (asynchronous, arst_n=0): all v[i]=0, all data[i]=PRESET_VAL, both counters 0. Outputs take these values immediately.
- Hold chain, combinational:
  - hold[DEPTH-1] = stall[DEPTH-1].
  - For i<DEPTH-1, with BUBBLE_COLLAPSE=1: hold[i] = stall[i] | (hold[i+1] & v[i+1]).
  - For i<DEPTH-1, with BUBBLE_COLLAPSE=0: hold[i] = stall[i] | hold[i+1].
- Per-stage update at a clock edge with enable=1, in priority order:
  1. flush[i]=1: v[i]<=0, data[i]<=PRESET_VAL. Flush wins over hold and over incoming data.
  2. Else if hold[i]=1: stage keeps its contents.
  3. Else, i=0: data[0]<=din, v[0]<=din_valid.
  4. Else, i>0 and hold[i-1]=0: data[i]<=data[i-1], v[i]<=v[i-1].
  5. Else, i>0 and hold[i-1]=1: bubble, v[i]<=0, data[i]<=PRESET_VAL.
- Flush ordering: a flush acts on the register at the edge. An entry leaving stage i-1 into a flushed stage i is lost. Stage i-1 itself still advances or holds per its own hold.
- Latency: with no holds or flushes, an entry presented on din at edge N appears on dout after edge N+DEPTH-1. Throughput is 1 entry per cycle.
- din handshake:
  - din is taken only when in_ready=1.
  - When in_ready=0, the producer must hold din and din_valid.
  - With flush[0]=1, din is dropped even if in_ready=1.
- Last stage: the consumer takes dout on every enabled edge where dout_valid & ~hold[DEPTH-1].
- stall_cycles: +1 on each enabled edge where OR over i of (hold[i] & v[i]) is 1. Saturates at all-ones, no wrap.
- flush_kills: + popcount(flush & v) on each enabled edge. Saturates at all-ones; an addition that would overflow clamps.
- clr_cnt=1: zeroes both counters on that edge, overriding any increment.
- enable=0: no register changes. hold is still computed; in_ready=0.
- DEPTH=1: hold[0]=stall[0] and stage 0 feeds dout directly.

Test Plan (DEPTH=4, DATA_W=32, PRESET_VAL=0, BUBBLE_COLLAPSE=1):
- Reset mid-stream: din 0x11,0x22,0x33 for 3 cycles, then arst_n=0 → stage_valid=4'b0000, dout=0, counters 0, all asynchronous (before next clk).
- Streaming: din=0xA0..0xA7 valid on consecutive cycles, no stall → dout 0xA0 after 4th edge, then one value per cycle in order. stall_cycles stays 0.
- Stall stage 2 for 2 cycles with all stages valid → stages 0–2 hold, stage 3 gets 2 bubbles (dout_valid=0 twice), in_ready=0 for 2 cycles, stall_cycles=2.
- Bubble collapse: only stage 0 valid, stall[3]=1 while stage 3 empty → stage 0 still advances and in_ready=1. Repeat with BUBBLE_COLLAPSE=0 → in_ready=0.
- Flush over stall: all valid, stall[1]=1 and flush=4'b0110 on the same edge → stages 1,2 invalid and 0, stage 0 holds, flush_kills=2.
- Saturation/clear/enable (CNT_W=2): 4 stalled cycles → stall_cycles=3 (held). Then clr_cnt → 0. Then enable=0 for 3 cycles with changing din → no state change.
